// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: streams A then B (row-major) into flat operand arrays, pulsing valid_o per complete pair.
// Define MATRIX_LOADER_DOUBLE_BUFFER_EN for a separate output bank with no EMIT stall.
module matrix_operand_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int A_ROWS = 4,
    parameter int B_COLUMNS = 4,
    parameter int A_COLUMNS_B_ROWS = 4,
    localparam int A_ELEMS = A_ROWS * A_COLUMNS_B_ROWS,
    localparam int B_ELEMS = A_COLUMNS_B_ROWS * B_COLUMNS
) (
    input  logic                                  clk,
    input  logic                                  reset_i,
    input  logic                                  clear_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [DATA_WIDTH-1:0]                 in_data_i,
    output logic                                  valid_o,
    output logic [A_ELEMS-1:0][DATA_WIDTH-1:0]    a_o,
    output logic [B_ELEMS-1:0][DATA_WIDTH-1:0]    b_o,
    output logic                                  busy_o
);
    localparam int CW = (A_ELEMS + B_ELEMS > 1) ? $clog2(A_ELEMS + B_ELEMS) : 1;

    if (A_ELEMS < 1 || B_ELEMS < 1) begin : g_param_check
        $error("matrix_operand_loader: A_ELEMS and B_ELEMS must be at least 1");
    end

    typedef enum logic [1:0] {LOAD_A, LOAD_B, EMIT} state_t;
`ifdef MATRIX_LOADER_DOUBLE_BUFFER_EN
    localparam state_t AFTER_B = LOAD_A;
`else
    localparam state_t AFTER_B = EMIT;
`endif

    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic busy;
    logic [A_ELEMS-1:0][DATA_WIDTH-1:0] a_fill, a_next;
    logic [B_ELEMS-1:0][DATA_WIDTH-1:0] b_fill, b_next;
    logic accept, last_a, last_b, pair_done;

    assign accept    = in_valid_i & in_ready_o;
    assign last_a    = cnt == CW'(A_ELEMS - 1);
    assign last_b    = cnt == CW'(A_ELEMS + B_ELEMS - 1);
    assign pair_done = accept & last_b & ~clear_i;

    always_ff @(posedge clk or posedge reset_i)
        if (reset_i) state <= LOAD_A;
        else state <= state_next;

    always_comb begin
        state_next = state;
        if (clear_i || state == EMIT) state_next = LOAD_A;
        else if (accept && state == LOAD_A && last_a) state_next = LOAD_B;
        else if (accept && state == LOAD_B && last_b) state_next = AFTER_B;
    end

    // Fill bank with the offered element merged in, so a bank copy on the final edge sees it
    always_comb begin
        a_next = a_fill;
        b_next = b_fill;
        for (int i = 0; i < A_ELEMS; i++) if (cnt == CW'(i)) a_next[i] = in_data_i;
        for (int j = 0; j < B_ELEMS; j++) if (cnt == CW'(A_ELEMS + j)) b_next[j] = in_data_i;
    end

    always_ff @(posedge clk or posedge reset_i)
        if (reset_i) begin
            cnt    <= '0;
            busy   <= 1'b0;
            a_fill <= '0;
            b_fill <= '0;
        end else if (clear_i) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (accept) begin
            cnt    <= last_b ? '0 : cnt + CW'(1);
`ifdef MATRIX_LOADER_DOUBLE_BUFFER_EN
            busy   <= ~last_b;
`else
            busy   <= 1'b1;
`endif
            a_fill <= a_next;
            b_fill <= b_next;
        end else if (state == EMIT) begin
            busy <= 1'b0;
        end

`ifdef MATRIX_LOADER_DOUBLE_BUFFER_EN
    logic valid_r;
    logic [A_ELEMS-1:0][DATA_WIDTH-1:0] a_bank;
    logic [B_ELEMS-1:0][DATA_WIDTH-1:0] b_bank;

    always_ff @(posedge clk or posedge reset_i)
        if (reset_i) begin
            valid_r <= 1'b0;
            a_bank  <= '0;
            b_bank  <= '0;
        end else begin
            valid_r <= pair_done;
            if (pair_done) begin
                a_bank <= a_next;
                b_bank <= b_next;
            end
        end

    assign a_o = a_bank;
    assign b_o = b_bank;
`else
    logic valid_r;
    assign valid_r = state == EMIT;
    assign a_o = a_fill;
    assign b_o = b_fill;
`endif

    always_comb begin
        in_ready_o = state != EMIT;
        valid_o    = valid_r;
        busy_o     = busy;
    end
endmodule
